// File: rtl/fp_accum_driver_if.sv
// Bundle of the operand stream, status and adder request signals for fp_accum_driver.
// Operand stream: a transfer occurs on a rising edge where in_valid && in_ready; in_data must be stable while in_valid is high.
interface fp_accum_driver_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        clear;
    logic [31:0] acc_out;
    logic [7:0]  count;
    logic        busy;
    logic        err_timeout;
    logic [31:0] add_A;
    logic [31:0] add_B;
    logic        add_start;
    logic        add_done;
    logic [31:0] add_ans;

    // master: operand producer plus adder; slave: the accumulator driver
    modport master (
        output in_valid, in_data, clear, add_done, add_ans,
        input  in_ready, acc_out, count, busy, err_timeout, add_A, add_B, add_start
    );

    modport slave (
        input  in_valid, in_data, clear, add_done, add_ans,
        output in_ready, acc_out, count, busy, err_timeout, add_A, add_B, add_start
    );
endinterface

// File: rtl/fp_accum_driver.sv
// Operand FIFO plus start/done sequencer keeping a running sum through an external multi-cycle FP adder.
// Optional FPACC_ZERO_SKIP_EN: +/-0 operands are retired in IDLE without an adder transaction.
module fp_accum_driver #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    fp_accum_driver_if.slave    bus,
    output logic [1:0]          state_dbg
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] OCC_FULL  = (AW + 1)'(DEPTH);
    localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ;
    logic [31:0]   acc;
    logic [31:0]   op_b;
    logic [7:0]    cnt;
    logic [7:0]    cnt_inc;
    logic [7:0]    wait_cnt;
    logic          err;
    logic          clr_pend;

    logic push, pop, fifo_empty;
    logic do_clear, do_capture, do_timeout, do_skip, load_b;

    assign fifo_empty = (occ == '0);
    assign push       = bus.in_valid && bus.in_ready;
    assign cnt_inc    = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

`ifdef FPACC_ZERO_SKIP_EN
    logic head_zero;
    assign head_zero = (mem[rd_ptr][30:0] == 31'd0);
`endif

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        do_clear   = 1'b0;
        do_capture = 1'b0;
        do_timeout = 1'b0;
        do_skip    = 1'b0;
        load_b     = 1'b0;
        unique case (state)
            S_IDLE: begin
                // a pending clear wins over starting the next operand
                if (bus.clear || clr_pend) begin
                    do_clear = 1'b1;
                end else if (!fifo_empty) begin
`ifdef FPACC_ZERO_SKIP_EN
                    if (head_zero) begin
                        do_skip = 1'b1;
                        pop     = 1'b1;
                    end else begin
                        load_b     = 1'b1;
                        state_next = S_ISSUE;
                    end
`else
                    load_b     = 1'b1;
                    state_next = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.add_done) begin
                    do_capture = 1'b1;
                    pop        = 1'b1;
                    state_next = S_IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    do_timeout = 1'b1;
                    pop        = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (do_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            acc      <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            clr_pend <= 1'b0;
            op_b     <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (do_clear) begin
                acc      <= '0;
                cnt      <= '0;
                err      <= 1'b0;
                clr_pend <= 1'b0;
            end else if (bus.clear) begin
                clr_pend <= 1'b1;
            end
            if (do_capture) begin
                acc <= bus.add_ans;
                cnt <= cnt_inc;
            end
            if (do_skip)    cnt  <= cnt_inc;
            if (do_timeout) err  <= 1'b1;
            if (load_b)     op_b <= mem[rd_ptr];
            if (state == S_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign bus.in_ready    = (occ != OCC_FULL);
    assign bus.busy        = (state != S_IDLE) || !fifo_empty;
    assign bus.add_start   = (state == S_ISSUE);
    assign bus.add_A       = acc;
    assign bus.add_B       = op_b;
    assign bus.acc_out     = acc;
    assign bus.count       = cnt;
    assign bus.err_timeout = err;
    assign state_dbg       = state;
endmodule

// File: tb/tb_fp_accum_driver.sv
// Directed scoreboard bench for fp_accum_driver with a behavioural multi-cycle adder model.
`timescale 1ns/1ps
module tb_fp_accum_driver;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam int M_NORMAL = 0;
    localparam int M_STALL  = 1;
    localparam int M_DEAD   = 2;
    localparam int M_STICKY = 3;

    localparam logic [31:0] ZERO  = 32'h0000_0000;
    localparam logic [31:0] ONE   = 32'h3F80_0000;
    localparam logic [31:0] TWO   = 32'h4000_0000;
    localparam logic [31:0] THREE = 32'h4040_0000;
    localparam logic [31:0] FOUR  = 32'h4080_0000;
    localparam logic [31:0] SIX   = 32'h40C0_0000;
    localparam logic [31:0] EIGHT = 32'h4100_0000;
    localparam logic [31:0] TEN   = 32'h4120_0000;
    localparam logic [31:0] NEGZ  = 32'h8000_0000;
    localparam logic [31:0] DENRM = 32'h0000_0001;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    fp_accum_driver_if bus();

    fp_accum_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] exp_start_q[$];
    logic [39:0] exp_res_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // adder model: exact sums for the operand pairs used here
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        if (b[30:23] == 8'd0 && a[30:23] != 8'd0) return a;
        if (a[30:0] == 31'd0) return b;
        if (b[30:0] == 31'd0) return a;
        case ({a, b})
            {ONE, TWO}:     return THREE;
            {THREE, THREE}: return SIX;
            {SIX, FOUR}:    return TEN;
            default:        return 32'h7FC0_0000;
        endcase
    endfunction

    int          mode = M_NORMAL;
    int          lat  = 5;
    int          lat_cnt;
    logic        m_busy;
    logic [31:0] pend;

    always @(posedge clk) begin
        if (!rst_n) begin
            bus.add_done <= 1'b0;
            bus.add_ans  <= '0;
            m_busy       <= 1'b0;
            lat_cnt      <= 0;
            pend         <= '0;
        end else if (mode == M_STICKY) begin
            bus.add_done <= 1'b1;
            m_busy       <= 1'b0;
            if (bus.add_start) bus.add_ans <= fp_add(bus.add_A, bus.add_B);
        end else if (bus.add_start) begin
            bus.add_done <= 1'b0;
            m_busy       <= (mode != M_DEAD);
            lat_cnt      <= lat;
            pend         <= fp_add(bus.add_A, bus.add_B);
        end else if (m_busy && mode == M_NORMAL) begin
            if (lat_cnt <= 1) begin
                bus.add_done <= 1'b1;
                bus.add_ans  <= pend;
                m_busy       <= 1'b0;
            end else begin
                bus.add_done <= 1'b0;
                lat_cnt      <= lat_cnt - 1;
            end
        end else begin
            bus.add_done <= 1'b0;
            if (mode == M_DEAD) m_busy <= 1'b0;
        end
    end

    // scoreboard monitor
    logic [39:0] last_res = '0;
    logic [63:0] cur_ops  = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.add_start) begin
                if (exp_start_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL start_unexpected: got A=%h B=%h, want no add_start", bus.add_A, bus.add_B);
                end else begin
                    cur_ops = exp_start_q.pop_front();
                    check("start_operands", {bus.add_A, bus.add_B}, cur_ops);
                end
            end
            if (state_dbg == ST_WAIT) check("wait_operands_held", {bus.add_A, bus.add_B}, cur_ops);
            if ({bus.acc_out, bus.count} !== last_res) begin
                last_res = {bus.acc_out, bus.count};
                if (exp_res_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL result_unexpected: got acc=%h count=%0d, want no change", bus.acc_out, bus.count);
                end else begin
                    check("result", {24'd0, last_res}, {24'd0, exp_res_q.pop_front()});
                end
            end
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] d);
        int g = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && g < 200) begin
            step(1);
            g++;
        end
        n_cmp++;
        if (!bus.in_ready) begin
            n_bad++;
            $display("FAIL push_ready: in_ready got 0 for %0d cycles, want 1", g);
        end
        step(1);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        while (bus.busy && g < 300) begin
            step(1);
            g++;
        end
        n_cmp++;
        if (bus.busy) begin
            n_bad++;
            $display("FAIL %s: busy got 1 after %0d cycles, want 0", name, g);
        end
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.clear    = 1'b0;
        step(3);

        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err_timeout, 0);
        check("rst_start", bus.add_start, 0);
        check("rst_add_A", bus.add_A, 0);
        check("rst_add_B", bus.add_B, 0);
        check("rst_acc", bus.acc_out, 0);
        check("rst_count", bus.count, 0);
        check("rst_state", state_dbg, ST_IDLE);
        rst_n = 1'b1;
        step(2);

        // two-operand sum with latency check
        exp_start_q.push_back({ZERO, ONE});
        exp_res_q.push_back({ONE, 8'd1});
        exp_start_q.push_back({ONE, TWO});
        exp_res_q.push_back({THREE, 8'd2});
        push(ONE);
        check("t1_cycle1_start", bus.add_start, 0);
        check("t1_cycle1_state", state_dbg, ST_IDLE);
        step(1);
        check("t1_cycle2_start", bus.add_start, 1);
        step(1);
        check("t1_cycle3_state", state_dbg, ST_WAIT);
        push(TWO);
        wait_idle("t1_idle");
        check("t1_acc", bus.acc_out, THREE);
        check("t1_count", bus.count, 2);

        // full FIFO with stalled adder
        exp_res_q.push_back({ZERO, 8'd0});
        pulse_clear();
        mode = M_STALL;
        exp_start_q.push_back({ZERO, ONE});
        exp_res_q.push_back({ONE, 8'd1});
        exp_start_q.push_back({ONE, TWO});
        exp_res_q.push_back({THREE, 8'd2});
        exp_start_q.push_back({THREE, THREE});
        exp_res_q.push_back({SIX, 8'd3});
        exp_start_q.push_back({SIX, FOUR});
        exp_res_q.push_back({TEN, 8'd4});
        push(ONE);
        push(TWO);
        push(THREE);
        push(FOUR);
        check("t2_full_ready", bus.in_ready, 0);
        check("t2_full_state", state_dbg, ST_WAIT);
        bus.in_valid = 1'b1;
        bus.in_data  = EIGHT;
        step(2);
        check("t2_fifth_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        mode = M_NORMAL;
        wait_idle("t2_idle");
        check("t2_acc", bus.acc_out, TEN);
        check("t2_count", bus.count, 4);

        // timeout
        exp_res_q.push_back({ZERO, 8'd0});
        pulse_clear();
        mode = M_DEAD;
        exp_start_q.push_back({ZERO, ONE});
        push(ONE);
        step(1);
        check("t3_issue", bus.add_start, 1);
        step(TIMEOUT);
        check("t3_err_early", bus.err_timeout, 0);
        step(1);
        check("t3_err_set", bus.err_timeout, 1);
        check("t3_state", state_dbg, ST_IDLE);
        check("t3_busy", bus.busy, 0);
        check("t3_acc", bus.acc_out, 0);
        check("t3_count", bus.count, 0);
        mode = M_NORMAL;
        exp_start_q.push_back({ZERO, TWO});
        exp_res_q.push_back({TWO, 8'd1});
        push(TWO);
        wait_idle("t3_idle");
        check("t3_next_acc", bus.acc_out, TWO);
        check("t3_next_count", bus.count, 1);
        check("t3_err_sticky", bus.err_timeout, 1);

        // clear while waiting, two entries queued
        exp_res_q.push_back({ZERO, 8'd0});
        pulse_clear();
        check("t4_err_cleared", bus.err_timeout, 0);
        exp_start_q.push_back({ZERO, ONE});
        exp_res_q.push_back({ONE, 8'd1});
        exp_res_q.push_back({ZERO, 8'd0});
        push(ONE);
        push(TWO);
        push(THREE);
        check("t4_state_wait", state_dbg, ST_WAIT);
        pulse_clear();
        wait_idle("t4_idle");
        check("t4_acc", bus.acc_out, 0);
        check("t4_count", bus.count, 0);
        check("t4_ready", bus.in_ready, 1);
        step(12);
        check("t4_busy", bus.busy, 0);

        // adder holding done high between operations
        mode = M_STICKY;
        step(3);
        exp_start_q.push_back({ZERO, TWO});
        exp_res_q.push_back({TWO, 8'd1});
        push(TWO);
        step(1);
        check("t5_issue_start", bus.add_start, 1);
        check("t5_issue_acc", bus.acc_out, 0);
        step(1);
        check("t5_wait_acc", bus.acc_out, 0);
        check("t5_wait_state", state_dbg, ST_WAIT);
        step(1);
        check("t5_capture_acc", bus.acc_out, TWO);
        check("t5_capture_count", bus.count, 1);
        mode = M_NORMAL;
        wait_idle("t5_idle");

        // zero operand, then a denormal that must still use the adder
        exp_res_q.push_back({TWO, 8'd2});
`ifdef FPACC_ZERO_SKIP_EN
        push(NEGZ);
        step(1);
        check("t6_skip_count", bus.count, 2);
        check("t6_skip_state", state_dbg, ST_IDLE);
        wait_idle("t6_idle");
`else
        exp_start_q.push_back({TWO, NEGZ});
        push(NEGZ);
        wait_idle("t6_idle");
`endif
        check("t6_acc", bus.acc_out, TWO);
        check("t6_count", bus.count, 2);
        exp_start_q.push_back({TWO, DENRM});
        exp_res_q.push_back({TWO, 8'd3});
        push(DENRM);
        wait_idle("t6_denorm_idle");
        check("t6_denorm_count", bus.count, 3);

        // reset in the middle of a transaction
        exp_start_q.push_back({TWO, ONE});
        exp_res_q.push_back({ZERO, 8'd0});
        push(ONE);
        step(2);
        check("t7_state_wait", state_dbg, ST_WAIT);
        rst_n = 1'b0;
        step(1);
        check("t7_rst_state", state_dbg, ST_IDLE);
        check("t7_rst_busy", bus.busy, 0);
        check("t7_rst_add_A", bus.add_A, 0);
        check("t7_rst_add_B", bus.add_B, 0);
        rst_n = 1'b1;
        step(15);
        check("t7_post_acc", bus.acc_out, 0);
        check("t7_post_count", bus.count, 0);

        check("start_queue_drained", exp_start_q.size(), 0);
        check("result_queue_drained", exp_res_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fp_accum_driver.md
# fp_accum_driver

Request-side companion to the multi-cycle floating-point adder: buffers a stream of IEEE-754 single-precision operands and drives the adder's `start`/`done` handshake to keep a running sum. Each accepted operand is added to the accumulator. The accumulator feeds back as operand A, and the adder result is captured when `done` is seen. The block sits between an operand producer and one adder instance, and owns every adder transaction.

## Interface

Parameters:
- `DEPTH`, 4: operand FIFO entries; power of two, 2..16.
- `TIMEOUT`, 64: maximum WAIT cycles before abort; 2..255.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: operand offered.
- `in_data`, in, 32: operand in IEEE-754 single format.
- `in_ready`, out, 1: FIFO not full.
- `clear`, in, 1: zero the accumulator and count, flush the FIFO, clear the error.
- `acc_out`, out, 32: current accumulator value.
- `count`, out, 8: operands summed; saturates at 255.
- `busy`, out, 1: state is not IDLE, or the FIFO is not empty.
- `err_timeout`, out, 1: sticky flag; adder did not respond in time.
- `add_A`, out, 32: adder operand A, the accumulator.
- `add_B`, out, 32: adder operand B, the FIFO head.
- `add_start`, out, 1: one-cycle request pulse to the adder.
- `add_done`, in, 1: adder completion.
- `add_ans`, in, 32: adder result; valid when `add_done` is high.

## Operation

- **FIFO.**
  - Circular buffer with separate read/write pointers and an occupancy counter.
  - A push occurs when `in_valid && in_ready`.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - When full, `in_ready`=0 and `in_data` is ignored.
- **State IDLE.**
  - If `clear`: acc=0x00000000, count=0, FIFO flushed, `err_timeout`=0. Stay in IDLE.
  - Otherwise, if the FIFO is not empty, go to ISSUE.
- **State ISSUE** (one cycle).
  - `add_start`=1; `add_A`=acc; `add_B`=FIFO head.
  - Reset the wait counter. Go to WAIT.
- **State WAIT.**
  - `add_A` and `add_B` are held stable.
  - The wait counter increments each cycle.
  - On the first cycle with `add_done`=1:
    - acc ← `add_ans`;
    - pop the FIFO;
    - count ← min(count+1, 255);
    - go to IDLE.
  - If the counter reaches `TIMEOUT` without `add_done`:
    - pop the entry, which is discarded; acc is unchanged;
    - set `err_timeout`;
    - go to IDLE.
- `add_done` is ignored outside WAIT, including the ISSUE cycle. This tolerates an adder that holds `done` high between operations.
- **`clear` outside IDLE.** The clear is latched as pending. It executes on the next entry to IDLE and takes precedence over starting a new ISSUE. Operands pushed while the clear is pending are flushed with it.
- **Arithmetic.** No arithmetic is done in this block: no rounding, special-case, NaN or infinity handling. `add_ans` is taken verbatim.

## Timing

- **Reset values.**
  - State IDLE, FIFO empty, acc=0, count=0.
  - `in_ready`=1, `busy`=0, `err_timeout`=0, `add_start`=0.
  - `add_A`=0, `add_B`=0.
- **Reset mid-transaction.** State is abandoned immediately. No `add_start` is issued after reset until a new push.
- **Latency**, with push at edge 0:
  - IDLE sees the FIFO non-empty in cycle 1;
  - `add_start` is high in cycle 2;
  - WAIT begins in cycle 3;
  - `acc_out` updates at the edge that samples `add_done`;
  - IDLE is re-entered the cycle after that edge.
- **Throughput.** One operand per (adder latency + 3) cycles. Back-to-back entries issue with no extra bubble beyond the IDLE cycle.
- `count` and `acc_out` change only at the same edge and are coherent.

## Configuration

- **`FPACC_ZERO_SKIP_EN` defined.**
  - In IDLE, an operand that is ±0 (exponent and mantissa fields all zero) is popped without an adder transaction.
  - acc is unchanged and count increments.
  - Takes one cycle; no `add_start` pulse.
- **Not defined.** Every operand, including zeros, goes through ISSUE/WAIT.

## Test plan

- **Two-operand sum.** Reset, then push 0x3F800000 (1.0) and 0x40000000 (2.0); model adder latency 5. Expect:
  - two `add_start` pulses; the first has `add_A`=0, `add_B`=0x3F800000;
  - final `acc_out`=0x40400000 (3.0), `count`=2;
  - `busy` falls after the second capture.
- **Full FIFO.** Adder model stalled with `add_done`=0; push until full. Expect `in_ready`=0 after `DEPTH` pushes, and the fifth value is not stored. Then release the adder and confirm all 4 values are summed in order.
- **Timeout.** Adder never asserts `add_done`. Expect:
  - `err_timeout`=1 exactly `TIMEOUT` cycles after WAIT entry;
  - acc=0, `count`=0, entry dropped;
  - the next operand still issues normally.
- **Clear mid-operation.** Assert `clear` for one cycle in WAIT, with 2 entries queued. Expect:
  - the current result is captured;
  - then acc=0, `count`=0, FIFO empty;
  - no further `add_start`.
- **Sticky done.** Adder holds `add_done`=1 before `add_start`. Expect the result is not captured in the ISSUE cycle; capture occurs only in WAIT.
- **Zero operand.** Push 0x80000000 (−0.0). With `FPACC_ZERO_SKIP_EN`: no `add_start`, `count`=1 after 2 cycles. Without it: one adder transaction.
